csa_resolver: RTL

//  Consumer end of the carry-save interface: accepts a redundant (sum, carry) vector pair,
//  as produced by the carry-save adder, and resolves it to plain binary.

---
 rtl/csa_resolver.sv | 121 ++++++++++++
 1 files changed

// File: rtl/csa_resolver.sv
// Resolves a carry-save (sum, carry) pair to binary with a chunked, multi-cycle carry-propagate.
// Each RESOLVE cycle adds one CHUNK-wide slice and registers the carry between slices.
module csa_resolver #(
    parameter int unsigned W     = 4,
    parameter int unsigned CHUNK = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_sum,
    input  logic [W-1:0]   in_carry,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W+1:0]   out_data,
    output logic           busy
);

    localparam int unsigned N    = W + 2;
    localparam int unsigned NCH  = N / CHUNK;
    localparam int unsigned IdxW = (NCH > 1) ? $clog2(NCH) : 1;

    if ((N % CHUNK) != 0) begin : g_bad_chunk
        $error("csa_resolver: (W+2) must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        StIdle,
        StResolve,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    res_q, res_d;
    logic [N-1:0]    out_q, out_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            cy_q, cy_d;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [N-1:0]     res_upd;
    logic             last_chunk;

    always_comb begin
        a_chunk    = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk    = b_q[idx_q*CHUNK +: CHUNK];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, cy_q};
        res_upd    = res_q;
        res_upd[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        last_chunk = (idx_q == IdxW'(NCH - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        out_d   = out_q;
        idx_d   = idx_q;
        cy_d    = cy_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = {2'b00, in_sum};
                    b_d     = {1'b0, in_carry, 1'b0};
                    res_d   = '0;
                    idx_d   = '0;
                    cy_d    = 1'b0;
                    state_d = StResolve;
                end
            end
            StResolve: begin
                res_d = res_upd;
                if (last_chunk) begin
                    // Range guarantees the final carry is zero, so it is dropped.
                    out_d   = res_upd;
                    idx_d   = '0;
                    cy_d    = 1'b0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                    cy_d  = chunk_sum[CHUNK];
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            cy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StResolve) || (state_q == StDone);
    assign out_data  = out_q;

endmodule
